// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a variable-latency
// memory (slave). Bus_Ack is a one-cycle completion strobe, and Bus_R_Data is valid with it.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              Bus_Req;
    logic              Bus_We;
    logic [ADDR_W-1:0] Bus_Addr;
    logic [3:0]        Bus_Byte_En;
    logic [31:0]       Bus_W_Data;
    logic              Bus_Ack;
    logic [31:0]       Bus_R_Data;

    modport master (
        output Bus_Req, Bus_We, Bus_Addr, Bus_Byte_En, Bus_W_Data,
        input  Bus_Ack, Bus_R_Data
    );

    modport slave (
        input  Bus_Req, Bus_We, Bus_Addr, Bus_Byte_En, Bus_W_Data,
        output Bus_Ack, Bus_R_Data
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: lane steering, byte enables, misalignment check,
// load extension and a bus timeout. The pipeline is stalled until the access completes.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MEM_R_En_M,
    input  logic                MEM_W_En_M,
    input  logic [2:0]          MEM_Control_M,
    input  logic [31:0]         ALU_Result_M,
    input  logic [31:0]         REG_R_Data2_M,
    output logic [31:0]         Load_Data_M,
    output logic                Stall_M,
    output logic                Misaligned_M,
    output logic                Bus_Error_M,
    load_store_unit_if.master   bus
);
    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    state_t state, state_nxt;

    logic              acc, we_in, is_byte, is_half, mis;
    logic [1:0]        off;
    logic [3:0]        be_in;
    logic [31:0]       wd_in;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        ctrl_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic [31:0]       load_q;
    logic              err_q;
    logic [CW-1:0]     cnt;
    logic              tmo_hit;
    logic [31:0]       lane, ext;

    // Request decode; any encoding that is not byte or half sizes as a word
    always_comb begin
        acc     = MEM_R_En_M | MEM_W_En_M;
        we_in   = MEM_W_En_M;
        off     = ALU_Result_M[1:0];
        is_byte = (MEM_Control_M == MEM_BYTE) || (MEM_Control_M == MEM_BYTE_UNSIGNED);
        is_half = (MEM_Control_M == MEM_HALFWORD) || (MEM_Control_M == MEM_HALFWORD_UNSIGNED);
        mis     = acc && ((is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00)));
        if (is_byte)      be_in = 4'b0001 << off;
        else if (is_half) be_in = off[1] ? 4'b1100 : 4'b0011;
        else              be_in = 4'b1111;
        if (!we_in)       wd_in = 32'h0;
        else if (is_byte) wd_in = {4{REG_R_Data2_M[7:0]}};
        else if (is_half) wd_in = {2{REG_R_Data2_M[15:0]}};
        else              wd_in = REG_R_Data2_M;
    end

    always_comb begin
        lane = bus.Bus_R_Data >> {off_q, 3'b000};
        case (ctrl_q)
            MEM_BYTE:              ext = {{24{lane[7]}}, lane[7:0]};
            MEM_BYTE_UNSIGNED:     ext = {24'h0, lane[7:0]};
            MEM_HALFWORD:          ext = {{16{lane[15]}}, lane[15:0]};
            MEM_HALFWORD_UNSIGNED: ext = {16'h0, lane[15:0]};
            default:               ext = lane;
        endcase
    end

    // cnt holds the number of REQ cycles already elapsed
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc && !mis) state_nxt = S_REQ;
            S_REQ:   if (bus.Bus_Ack || tmo_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Bus_Req     = (state == S_REQ);
        bus.Bus_We      = (state == S_REQ) ? we_q : 1'b0;
        bus.Bus_Addr    = (state == S_REQ) ? addr_q : '0;
        bus.Bus_Byte_En = (state == S_REQ) ? be_q : 4'h0;
        bus.Bus_W_Data  = (state == S_REQ) ? wd_q : 32'h0;
        Stall_M         = 1'b0;
        if (!RST) begin
            if (state == S_IDLE)     Stall_M = acc && !mis;
            else if (state == S_REQ) Stall_M = 1'b1;
        end
        Misaligned_M    = !RST && (state == S_IDLE) && mis;
        // A misaligned load must hand zero to writeback even though load_q still holds
        Load_Data_M     = ((state == S_IDLE) && mis) ? 32'h0 : load_q;
        Bus_Error_M     = err_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
            ctrl_q <= 3'b0;
            off_q  <= 2'b0;
            we_q   <= 1'b0;
            be_q   <= 4'h0;
            wd_q   <= 32'h0;
            load_q <= 32'h0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (acc && !mis) begin
                        addr_q <= {ALU_Result_M[ADDR_W-1:2], 2'b00};
                        ctrl_q <= MEM_Control_M;
                        off_q  <= off;
                        we_q   <= we_in;
                        be_q   <= be_in;
                        wd_q   <= wd_in;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (bus.Bus_Ack) begin
                        load_q <= ext;
                    end else if (tmo_hit) begin
                        load_q <= 32'h0;
                        err_q  <= 1'b1;
                    end
                end
                S_DONE:  err_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with a 4-cycle bus timeout.
module tb_load_store_unit;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MEM_R_En_M = 1'b0, MEM_W_En_M = 1'b0;
    logic [2:0]  MEM_Control_M = 3'b0;
    logic [31:0] ALU_Result_M = 32'h0, REG_R_Data2_M = 32'h0;
    logic [31:0] Load_Data_M;
    logic        Stall_M, Misaligned_M, Bus_Error_M;

    int checks = 0, errors = 0;

    // Observations from the most recent access
    logic [31:0] o_addr, o_be, o_wd, o_we, o_mis, o_stall0, o_load, o_err, o_err_after, o_done_stall;
    int          req_cnt, stall_cnt;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .MEM_R_En_M(MEM_R_En_M), .MEM_W_En_M(MEM_W_En_M),
        .MEM_Control_M(MEM_Control_M), .ALU_Result_M(ALU_Result_M),
        .REG_R_Data2_M(REG_R_Data2_M), .Load_Data_M(Load_Data_M),
        .Stall_M(Stall_M), .Misaligned_M(Misaligned_M), .Bus_Error_M(Bus_Error_M),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one access; ack_after = index of the REQ cycle carrying Bus_Ack (0 = never)
    task automatic access(input logic we, input logic re, input logic [2:0] ctrl,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int ack_after, input logic [31:0] rdata);
        MEM_W_En_M = we; MEM_R_En_M = re; MEM_Control_M = ctrl;
        ALU_Result_M = addr; REG_R_Data2_M = data;
        #1;
        o_mis = {31'b0, Misaligned_M}; o_stall0 = {31'b0, Stall_M};
        o_load = Load_Data_M;
        req_cnt = 0; stall_cnt = Stall_M ? 1 : 0;
        o_addr = 0; o_be = 0; o_wd = 0; o_we = 0;
        @(posedge CLK); #1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.Bus_Req) break;
            req_cnt++;
            if (Stall_M) stall_cnt++;
            if (req_cnt == 1) begin
                o_addr = bus.Bus_Addr; o_be = {28'b0, bus.Bus_Byte_En};
                o_wd = bus.Bus_W_Data; o_we = {31'b0, bus.Bus_We};
            end
            if (req_cnt == ack_after) begin
                bus.Bus_Ack = 1'b1; bus.Bus_R_Data = rdata;
            end
            @(posedge CLK); #1;
            bus.Bus_Ack = 1'b0; bus.Bus_R_Data = 32'h0;
        end
        o_done_stall = {31'b0, Stall_M};
        o_err = {31'b0, Bus_Error_M};
        if (req_cnt > 0) o_load = Load_Data_M;
        MEM_W_En_M = 1'b0; MEM_R_En_M = 1'b0; ALU_Result_M = 32'h0; REG_R_Data2_M = 32'h0;
        @(posedge CLK); #1;
        o_err_after = {31'b0, Bus_Error_M};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Bus_Ack = 1'b0; bus.Bus_R_Data = 32'h0;
        #2;
        chk("rst_load",  Load_Data_M, 32'h0);
        chk("rst_stall", {31'b0, Stall_M}, 32'h0);
        chk("rst_req",   {31'b0, bus.Bus_Req}, 32'h0);
        chk("rst_err",   {31'b0, Bus_Error_M}, 32'h0);
        chk("rst_be",    {28'b0, bus.Bus_Byte_En}, 32'h0);
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); #1;

        access(1, 0, W, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        chk("sw_addr", o_addr, 32'h100);
        chk("sw_be", o_be, 32'hF);
        chk("sw_wd", o_wd, 32'hDEADBEEF);
        chk("sw_we", o_we, 32'h1);
        chk("sw_req_cycles", req_cnt, 2);
        chk("sw_stall_cycles", stall_cnt, 3);
        chk("sw_done_stall", o_done_stall, 32'h0);

        access(1, 0, B, 32'h101, 32'h12345678, 1, 32'h0);
        chk("sb_wd", o_wd, 32'h78787878);
        chk("sb_be", o_be, 32'h2);
        chk("sb_addr", o_addr, 32'h100);
        chk("sb_req_cycles", req_cnt, 1);

        access(0, 1, B, 32'h103, 32'h0, 1, 32'h80FF0000);
        chk("lb_be", o_be, 32'h8);
        chk("lb_we", o_we, 32'h0);
        chk("lb_wd", o_wd, 32'h0);
        chk("lb_data", o_load, 32'hFFFFFF80);

        access(0, 1, BU, 32'h103, 32'h0, 1, 32'h80FF0000);
        chk("lbu_data", o_load, 32'h00000080);

        access(0, 1, H, 32'h102, 32'h0, 1, 32'h80011234);
        chk("lh_be", o_be, 32'hC);
        chk("lh_data", o_load, 32'hFFFF8001);

        access(0, 1, HU, 32'h102, 32'h0, 1, 32'h80011234);
        chk("lhu_data", o_load, 32'h00008001);
        chk("lhu_hold", Load_Data_M, 32'h00008001);

        // Reset in the middle of a request
        MEM_R_En_M = 1'b1; MEM_Control_M = W; ALU_Result_M = 32'h10;
        @(posedge CLK); #1;
        chk("mid_req_up", {31'b0, bus.Bus_Req}, 32'h1);
        RST = 1'b1; #1;
        chk("mid_rst_req", {31'b0, bus.Bus_Req}, 32'h0);
        chk("mid_rst_stall", {31'b0, Stall_M}, 32'h0);
        chk("mid_rst_load", Load_Data_M, 32'h0);
        @(posedge CLK); #1; RST = 1'b0; MEM_R_En_M = 1'b0;
        @(posedge CLK); #1;

        access(0, 1, W, 32'h10, 32'h0, 1, 32'hCAFEF00D);
        chk("lw_after_rst_addr", o_addr, 32'h10);
        chk("lw_after_rst_data", o_load, 32'hCAFEF00D);

        access(0, 1, W, 32'h102, 32'h0, 1, 32'h11111111);
        chk("lw_mis_flag", o_mis, 32'h1);
        chk("lw_mis_stall", o_stall0, 32'h0);
        chk("lw_mis_req", req_cnt, 0);
        chk("lw_mis_load", o_load, 32'h0);

        access(1, 0, H, 32'h101, 32'hAAAA5555, 1, 32'h0);
        chk("sh_mis_flag", o_mis, 32'h1);
        chk("sh_mis_req", req_cnt, 0);
        chk("sh_mis_stall", o_stall0, 32'h0);

        access(0, 1, B, 32'h103, 32'h0, 1, 32'h7F000000);
        chk("lb_pos_mis", o_mis, 32'h0);
        chk("lb_pos_data", o_load, 32'h0000007F);

        access(0, 1, W, 32'h200, 32'h0, 0, 32'h0);
        chk("tmo_req_cycles", req_cnt, 4);
        chk("tmo_err", o_err, 32'h1);
        chk("tmo_load", o_load, 32'h0);
        chk("tmo_done_stall", o_done_stall, 32'h0);
        chk("tmo_err_clear", o_err_after, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
